ram_lsu_if: RTL and testbench
=============================

# ram_lsu_if

Load/store front end for the data RAM: accepts one memory request at a time over a valid/ready channel and drives the RAM's word address, byte-select, write-enable and write-data pins directly. It steers byte/halfword write data onto the correct lanes and realigns/sign-extends read data coming back from the RAM's one-cycle synchronous read port. Misaligned and illegal-size accesses are rejected with an error response and never reach the RAM. It sits between the core's load/store unit and the `ram` wrapper.

## Interface
- ERR_ON_MISALIGN, 1: 1 = misaligned access returns error, no RAM access; 0 = misaligned access is performed with addr[1:0] forced per size (half: addr[0]=0, word: addr[1:0]=0), no error.
- clk  in  1  clock, all state rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid_i  in  1  request present.
- req_ready_o  out  1  request accepted when valid&ready ("accept").
- req_addr_i  in  32  byte address.
- req_we_i  in  1  1 = store, 0 = load.
- req_size_i  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned_i  in  1  loads: 1 zero-extend, 0 sign-extend.
- req_wdata_i  in  32  store data, right-justified.
- rsp_valid_o  out  1  response present.
- rsp_ready_i  in  1  response consumed when valid&ready.
- rsp_rdata_o  out  32  load data (0 for stores/errors).
- rsp_err_o  out  1  misaligned or illegal size.
- ram_addr_o  out  32  byte address to RAM (RAM drops bits [1:0]).
- ram_data_o  out  32  lane-replicated write data.
- ram_sel_o  out  4  byte enables.
- ram_we_o  out  1  write strobe.
- ram_data_i  in  32  RAM read data, valid one cycle after address.

## Operation
- FSM states: IDLE, RD_WAIT, RSP. Reset state IDLE.
- req_ready_o = (state==IDLE) & ~rst. One transaction outstanding.
- Alignment check on accept: half with addr[0]=1, word with addr[1:0]!=0, size 11 -> bad. Size 11 is always an error regardless of ERR_ON_MISALIGN.
- IDLE, accept, bad (error case): no RAM access (ram_we_o=0), latch err=1, rdata=0 -> RSP.
- IDLE, accept, store: same cycle ram_we_o=1, ram_addr_o=req_addr_i, ram_sel_o/ram_data_o from size/addr; latch err=0, rdata=0 -> RSP.
- IDLE, accept, load: same cycle ram_we_o=0, ram_addr_o=req_addr_i; latch addr[1:0], size, unsigned -> RD_WAIT.
- RD_WAIT: capture ram_data_i, extract lane, extend -> RSP. Unconditional, one cycle.
- RSP: rsp_valid_o=1, rsp_rdata_o/rsp_err_o stable; on rsp_ready_i -> IDLE.
- ram_sel_o: byte 0001<<addr[1:0]; half 0011 (addr[1]=0) or 1100; word 1111. ram_sel_o=0 whenever ram_we_o=0.
- ram_data_o: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word wdata.
- Load extract: byte = ram_data_i[8*a+7:8*a], half = ram_data_i[16*a1+15:16*a1]; extend to 32 per unsigned flag.
- ram_addr_o = req_addr_i in IDLE (combinational, don't-care when no accept); held at latched address otherwise.

## Timing
- Store/error: accept cycle N, rsp_valid_o high from N+1.
- Load: accept N, RAM data at N+1, rsp_valid_o high from N+2.
- Back-to-back: next accept at earliest the cycle after response handshake; throughput one access per 2 (store) / 3 (load) cycles.
- rsp_ready_i low: response held indefinitely, no new accept.
- Reset values: rsp_valid_o 0, rsp_rdata_o 0, rsp_err_o 0, ram_we_o 0, ram_sel_o 0, req_ready_o 0 while rst high.
- Reset mid-transaction: pending load/response discarded, no RAM write issued after reset deasserts, state IDLE.
- ram_we_o is asserted for exactly one cycle per store.

## Test plan
- Word store 0xDEADBEEF to 0x100, then word load 0x100 -> ram_we_o 1 cycle, sel 1111; load rsp at N+2 rdata 0xDEADBEEF, err 0.
- Byte stores 0x11,0x22,0x33,0x44 to 0x200..0x203 -> sel 0001/0010/0100/1000, data 0x11111111 etc.; word load returns 0x44332211.
- Signed/unsigned loads of 0x80FF7F81 at 0x300: lb @0x300 -> 0xFFFFFF81, lbu @0x303 -> 0x00000080, lh @0x302 -> 0xFFFF80FF, lhu @0x300 -> 0x00007F81.
- Misaligned word load @0x101 and size 11 -> no RAM access, rsp at N+1 err 1 rdata 0; with ERR_ON_MISALIGN=0 misaligned load returns word @0x100, err 0.
- Hold rsp_ready_i low 5 cycles after load -> rsp_valid_o/rdata stable, req_ready_o 0; release -> req_ready_o 1 next cycle.
- Assert rst in RD_WAIT and in RSP -> rsp_valid_o drops asynchronously, no ram_we_o pulse, fresh request after reset completes normally.

Source files
------------

// File: rtl/ram_lsu_if.sv
// rtl/ram_lsu_if.sv - load/store front end driving a synchronous-read data RAM.
// One transaction outstanding; stores and errors answer next cycle, loads one later.
module ram_lsu_if #(
  parameter logic ERR_ON_MISALIGN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] req_addr_i,
  input  logic        req_we_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic [31:0] ram_addr_o,
  output logic [31:0] ram_data_o,
  output logic [3:0]  ram_sel_o,
  output logic        ram_we_o,
  input  logic [31:0] ram_data_i
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, RSP} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        accept;
  logic        misalign;
  logic        bad;
  logic [31:0] eff_addr;
  logic [3:0]  wr_sel;
  logic [31:0] wr_data;
  logic [31:0] byte_shift;
  logic [31:0] half_shift;

  assign req_ready_o = (state_q == IDLE) & ~rst;
  assign rsp_valid_o = (state_q == RSP);
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;
  assign accept      = req_valid_i & req_ready_o;

  always_comb begin
    misalign = ((req_size_i == 2'b01) & req_addr_i[0]) |
               ((req_size_i == 2'b10) & (|req_addr_i[1:0]));
    bad      = (req_size_i == 2'b11) | (ERR_ON_MISALIGN & misalign);

    // With errors disabled, misaligned accesses are snapped down to the natural boundary.
    eff_addr = req_addr_i;
    if (req_size_i == 2'b01) eff_addr[0]   = 1'b0;
    if (req_size_i == 2'b10) eff_addr[1:0] = 2'b00;

    case (req_size_i)
      2'b00:   wr_sel = 4'b0001 << eff_addr[1:0];
      2'b01:   wr_sel = eff_addr[1] ? 4'b1100 : 4'b0011;
      2'b10:   wr_sel = 4'b1111;
      default: wr_sel = 4'b0000;
    endcase

    case (req_size_i)
      2'b00:   wr_data = {4{req_wdata_i[7:0]}};
      2'b01:   wr_data = {2{req_wdata_i[15:0]}};
      default: wr_data = req_wdata_i;
    endcase

    byte_shift = ram_data_i >> {addr_q[1:0], 3'b000};
    half_shift = ram_data_i >> {addr_q[1], 4'b0000};
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    size_d     = size_q;
    uns_d      = uns_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    ram_addr_o = addr_q;
    ram_data_o = wr_data;
    ram_sel_o  = 4'b0000;
    ram_we_o   = 1'b0;

    case (state_q)
      IDLE: begin
        ram_addr_o = eff_addr;
        if (accept) begin
          addr_d = eff_addr;
          if (bad) begin
            err_d   = 1'b1;
            rdata_d = 32'h0;
            state_d = RSP;
          end else if (req_we_i) begin
            ram_we_o  = 1'b1;
            ram_sel_o = wr_sel;
            err_d     = 1'b0;
            rdata_d   = 32'h0;
            state_d   = RSP;
          end else begin
            size_d  = req_size_i;
            uns_d   = req_unsigned_i;
            err_d   = 1'b0;
            state_d = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        case (size_q)
          2'b00:   rdata_d = {{24{~uns_q & byte_shift[7]}}, byte_shift[7:0]};
          2'b01:   rdata_d = {{16{~uns_q & half_shift[15]}}, half_shift[15:0]};
          default: rdata_d = ram_data_i;
        endcase
        state_d = RSP;
      end
      RSP: begin
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= 32'h0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_ram_lsu_if.sv
// tb/tb_ram_lsu_if.sv - scoreboard bench for ram_lsu_if with a byte-array reference memory.
module tb_ram_lsu_if;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        req_valid_i = 0, req_we_i = 0, req_unsigned_i = 0, rsp_ready_i = 0;
  logic [31:0] req_addr_i = 0, req_wdata_i = 0;
  logic [1:0]  req_size_i = 0;
  logic        req_ready_o, rsp_valid_o, rsp_err_o, ram_we_o;
  logic [31:0] rsp_rdata_o, ram_addr_o, ram_data_o;
  logic [31:0] ram_data_i = 0;
  logic [3:0]  ram_sel_o;

  logic        b_req_valid_i = 0, b_req_we_i = 0, b_req_unsigned_i = 0, b_rsp_ready_i = 1;
  logic [31:0] b_req_addr_i = 0, b_req_wdata_i = 0;
  logic [1:0]  b_req_size_i = 0;
  logic        b_req_ready_o, b_rsp_valid_o, b_rsp_err_o, b_ram_we_o;
  logic [31:0] b_rsp_rdata_o, b_ram_addr_o, b_ram_data_o;
  logic [31:0] b_ram_data_i = 0;
  logic [3:0]  b_ram_sel_o;

  ram_lsu_if u_dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
    .req_we_i(req_we_i), .req_size_i(req_size_i), .req_unsigned_i(req_unsigned_i),
    .req_wdata_i(req_wdata_i), .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o), .ram_addr_o(ram_addr_o),
    .ram_data_o(ram_data_o), .ram_sel_o(ram_sel_o), .ram_we_o(ram_we_o),
    .ram_data_i(ram_data_i)
  );

  ram_lsu_if #(.ERR_ON_MISALIGN(1'b0)) u_dut_b (
    .clk(clk), .rst(rst),
    .req_valid_i(b_req_valid_i), .req_ready_o(b_req_ready_o), .req_addr_i(b_req_addr_i),
    .req_we_i(b_req_we_i), .req_size_i(b_req_size_i), .req_unsigned_i(b_req_unsigned_i),
    .req_wdata_i(b_req_wdata_i), .rsp_valid_o(b_rsp_valid_o), .rsp_ready_i(b_rsp_ready_i),
    .rsp_rdata_o(b_rsp_rdata_o), .rsp_err_o(b_rsp_err_o), .ram_addr_o(b_ram_addr_o),
    .ram_data_o(b_ram_data_o), .ram_sel_o(b_ram_sel_o), .ram_we_o(b_ram_we_o),
    .ram_data_i(b_ram_data_i)
  );

  // Synchronous-read RAMs behind each instance
  logic [31:0] mem_a [0:255] = '{default: 32'h0};
  logic [31:0] mem_b [0:255] = '{default: 32'h0};
  always @(posedge clk) begin
    if (ram_we_o)
      for (int i = 0; i < 4; i++)
        if (ram_sel_o[i]) mem_a[ram_addr_o[9:2]][8*i +: 8] <= ram_data_o[8*i +: 8];
    ram_data_i <= mem_a[ram_addr_o[9:2]];
  end
  always @(posedge clk) begin
    if (b_ram_we_o)
      for (int i = 0; i < 4; i++)
        if (b_ram_sel_o[i]) mem_b[b_ram_addr_o[9:2]][8*i +: 8] <= b_ram_data_o[8*i +: 8];
    b_ram_data_i <= mem_b[b_ram_addr_o[9:2]];
  end

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          acc;
    int          lat;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] ref_mem [0:1023] = '{default: 8'h0};
  int         checks = 0, errors = 0;
  int         cyc = 0, we_cnt = 0, exp_we = 0;
  logic       hold = 1'b0;
  logic       seen = 1'b0, post = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (ram_we_o) we_cnt <= we_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk); #1;
    rsp_ready_i = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  // Monitor: compares every presented response against the scoreboard head
  always @(negedge clk) begin
    if (rst) begin
      seen <= 1'b0;
      post <= 1'b0;
    end else begin
      if (post) chk("ready_after_rsp", 32'(req_ready_o), 32'd1);
      post <= 1'b0;
      if (rsp_valid_o) begin
        chk("ready_while_rsp", 32'(req_ready_o), 32'd0);
        if (sb.size() == 0) begin
          chk("unexpected_rsp", 32'(rsp_valid_o), 32'd0);
        end else begin
          if (!seen) chk("latency", 32'(cyc), 32'(sb[0].acc + sb[0].lat));
          chk("rsp_rdata", rsp_rdata_o, sb[0].rdata);
          chk("rsp_err", 32'(rsp_err_o), 32'(sb[0].err));
          if (rsp_ready_i) begin
            void'(sb.pop_front());
            seen <= 1'b0;
            post <= 1'b1;
          end else begin
            seen <= 1'b1;
          end
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic issue(input logic [31:0] addr, input logic we, input logic [1:0] size,
                       input logic uns, input logic [31:0] wdata);
    exp_t        e;
    int          n, ai, waited;
    logic        bad;
    logic [3:0]  sel;
    logic [31:0] dat, v;
    ai  = int'(addr[1:0]);
    n   = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    bad = (size == 2'd3) || (ai % n != 0);
    sel = 4'h0;
    dat = 32'h0;
    v   = 32'h0;
    for (int i = 0; i < 4; i++) begin
      dat[8*i +: 8] = wdata[8*(i % n) +: 8];
      if (i >= ai && i < ai + n) sel[i] = 1'b1;
    end
    if (!bad && !we) begin
      for (int k = 0; k < n; k++) v[8*k +: 8] = ref_mem[int'(addr[9:0]) + k];
      if (!uns && v[8*n-1])
        for (int k = n; k < 4; k++) v[8*k +: 8] = 8'hFF;
    end
    e.err   = bad;
    e.rdata = v;
    e.lat   = (bad || we) ? 1 : 2;

    req_addr_i = addr; req_we_i = we; req_size_i = size;
    req_unsigned_i = uns; req_wdata_i = wdata; req_valid_i = 1'b1;
    waited = 0;
    @(negedge clk);
    while (!req_ready_o && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    chk("accept_timeout", 32'(req_ready_o), 32'd1);
    if (req_ready_o) begin
      chk("ram_we", 32'(ram_we_o), 32'(we && !bad));
      chk("ram_sel", 32'(ram_sel_o), (we && !bad) ? 32'(sel) : 32'd0);
      if (we && !bad) begin
        chk("ram_data", ram_data_o, dat);
        for (int k = 0; k < n; k++) ref_mem[int'(addr[9:0]) + k] = wdata[8*k +: 8];
        exp_we++;
      end
      if (!bad) chk("ram_addr", {ram_addr_o[31:2], 2'b00}, {addr[31:2], 2'b00});
      e.acc = cyc;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    req_valid_i = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 100) begin
      @(posedge clk);
      t++;
    end
    chk("drain", 32'(sb.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic b_xact(input string name, input logic [31:0] addr, input logic we,
                        input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                        input logic exp_err, input logic [31:0] exp_rd);
    int t = 0;
    b_req_addr_i = addr; b_req_we_i = we; b_req_size_i = size;
    b_req_unsigned_i = uns; b_req_wdata_i = wdata; b_req_valid_i = 1'b1;
    @(negedge clk);
    while (!b_req_ready_o && t < 50) begin
      @(negedge clk);
      t++;
    end
    @(posedge clk); #1;
    b_req_valid_i = 1'b0;
    t = 0;
    @(negedge clk);
    while (!b_rsp_valid_o && t < 10) begin
      @(negedge clk);
      t++;
    end
    chk({name, "_valid"}, 32'(b_rsp_valid_o), 32'd1);
    chk({name, "_err"}, 32'(b_rsp_err_o), 32'(exp_err));
    chk({name, "_rdata"}, b_rsp_rdata_o, exp_rd);
    @(posedge clk); #1;
  endtask

  initial begin
    req_valid_i = 1'b1; req_we_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    chk("rst_rdata", rsp_rdata_o, 32'd0);
    chk("rst_err", 32'(rsp_err_o), 32'd0);
    chk("rst_we", 32'(ram_we_o), 32'd0);
    chk("rst_sel", 32'(ram_sel_o), 32'd0);
    chk("rst_ready", 32'(req_ready_o), 32'd0);
    req_valid_i = 1'b0; req_we_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    issue(32'h100, 1, 2'd2, 0, 32'hDEADBEEF);
    issue(32'h100, 0, 2'd2, 0, 32'h0);
    for (int i = 0; i < 4; i++) issue(32'h200 + i, 1, 2'd0, 0, 32'h11 * (i + 1));
    issue(32'h200, 0, 2'd2, 0, 32'h0);
    issue(32'h300, 1, 2'd2, 0, 32'h80FF7F81);
    issue(32'h300, 0, 2'd0, 0, 32'h0);
    issue(32'h303, 0, 2'd0, 1, 32'h0);
    issue(32'h302, 0, 2'd1, 0, 32'h0);
    issue(32'h300, 0, 2'd1, 1, 32'h0);
    issue(32'h101, 0, 2'd2, 0, 32'h0);
    issue(32'h100, 0, 2'd3, 0, 32'h0);
    issue(32'h100, 1, 2'd3, 0, 32'h12345678);
    issue(32'h301, 1, 2'd1, 0, 32'hFFFF);

    for (int i = 0; i < 150; i++) begin
      issue({22'h0, 10'($urandom_range(0, 1023))}, 1'($urandom_range(0, 1)),
            2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    drain();

    hold = 1'b1;
    issue(32'h100, 0, 2'd2, 0, 32'h0);
    repeat (7) begin @(posedge clk); #1; end
    hold = 1'b0;
    drain();

    hold = 1'b1;
    issue(32'h200, 0, 2'd2, 0, 32'h0);
    #2 rst = 1'b1;
    #1 chk("rst_rdwait_valid", 32'(rsp_valid_o), 32'd0);
    chk("rst_rdwait_we", 32'(ram_we_o), 32'd0);
    sb.delete();
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("rst_rdwait_no_rsp", 32'(rsp_valid_o), 32'd0);

    issue(32'h204, 1, 2'd2, 0, 32'hA5A5A5A5);
    @(negedge clk);
    chk("rsp_before_rst", 32'(rsp_valid_o), 32'd1);
    #2 rst = 1'b1;
    #1 chk("rst_rsp_async_drop", 32'(rsp_valid_o), 32'd0);
    sb.delete();
    @(posedge clk); #1 rst = 1'b0;
    hold = 1'b0;
    issue(32'h204, 0, 2'd2, 0, 32'h0);
    issue(32'h200, 0, 2'd2, 0, 32'h0);
    drain();

    b_xact("b_sw", 32'h100, 1, 2'd2, 0, 32'hCAFEF00D, 1'b0, 32'h0);
    b_xact("b_lw_mis", 32'h101, 0, 2'd2, 0, 32'h0, 1'b0, 32'hCAFEF00D);
    b_xact("b_lhu_mis", 32'h103, 0, 2'd1, 1, 32'h0, 1'b0, 32'h0000CAFE);
    b_xact("b_lh_mis", 32'h101, 0, 2'd1, 0, 32'h0, 1'b0, 32'hFFFFF00D);
    b_xact("b_size3", 32'h100, 0, 2'd3, 0, 32'h0, 1'b1, 32'h0);
    b_xact("b_sh_mis", 32'h103, 1, 2'd1, 0, 32'h1234, 1'b0, 32'h0);
    b_xact("b_lw", 32'h100, 0, 2'd2, 0, 32'h0, 1'b0, 32'h1234F00D);

    @(posedge clk); #1;
    chk("we_pulse_count", 32'(we_cnt), 32'(exp_we));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
